// File: rtl/wb_stage_nway.sv
// N-lane write-back stage: per-lane load/ALU select, r0 and same-bundle WAW suppression, perf counters.
// One cycle to registered outputs; wb_stall_OUT is combinational and holds the whole bundle while any load waits.
module wb_stage_nway #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [LANES-1:0]        do_writeback,
  input  logic [LANES-1:0]        MemtoReg,
  input  logic [LANES-1:0]        mem_valid,
  input  logic                    flush,
  input  logic [LANES*DATA_W-1:0] aluResult,
  input  logic [LANES*DATA_W-1:0] Data_input,
  input  logic [LANES*REG_AW-1:0] writeRegister,
  output logic [LANES*DATA_W-1:0] writeData_OUT,
  output logic [LANES*REG_AW-1:0] writeRegister_OUT,
  output logic [LANES-1:0]        do_writeback_OUT,
  output logic                    wb_stall_OUT,
  output logic [31:0]             retired_count_OUT,
  output logic [STALL_CNT_W-1:0]  stall_cycles_OUT
);

  localparam int PC_W = $clog2(LANES + 1);

  logic [LANES*DATA_W-1:0] sel_dat;
  logic [LANES-1:0]        wait_vec;
  logic [LANES-1:0]        commit_vec;
  logic [PC_W-1:0]         commit_cnt;
  logic                    stall;

  logic [LANES*DATA_W-1:0] wdata_q;
  logic [LANES*REG_AW-1:0] wreg_q;
  logic [LANES-1:0]        wen_q;
  logic [31:0]             retired_q;
  logic [STALL_CNT_W-1:0]  stall_q;

  // Younger lanes (higher index) win a destination conflict, so older lanes drop their enable.
  always_comb begin
    sel_dat    = '0;
    wait_vec   = '0;
    commit_vec = '0;
    commit_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      sel_dat[k*DATA_W +: DATA_W] = MemtoReg[k] ? Data_input[k*DATA_W +: DATA_W]
                                                : aluResult[k*DATA_W +: DATA_W];
      wait_vec[k]   = do_writeback[k] & MemtoReg[k] & ~mem_valid[k];
      commit_vec[k] = do_writeback[k] & (writeRegister[k*REG_AW +: REG_AW] != '0);
      for (int j = k + 1; j < LANES; j++) begin
        if (do_writeback[j] &&
            (writeRegister[j*REG_AW +: REG_AW] == writeRegister[k*REG_AW +: REG_AW]))
          commit_vec[k] = 1'b0;
      end
      commit_cnt = commit_cnt + PC_W'(commit_vec[k]);
    end
  end

  assign stall = |wait_vec;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wdata_q   <= '0;
      wreg_q    <= '0;
      wen_q     <= '0;
      retired_q <= '0;
      stall_q   <= '0;
    end else if (flush) begin
      wen_q <= '0;
    end else if (stall) begin
      wen_q <= '0;
      if (stall_q != {STALL_CNT_W{1'b1}})
        stall_q <= stall_q + STALL_CNT_W'(1);
    end else begin
      wdata_q   <= sel_dat;
      wreg_q    <= writeRegister;
      wen_q     <= commit_vec;
      retired_q <= retired_q + 32'(commit_cnt);
    end
  end

  assign writeData_OUT     = wdata_q;
  assign writeRegister_OUT = wreg_q;
  assign do_writeback_OUT  = wen_q;
  assign wb_stall_OUT      = stall;
  assign retired_count_OUT = retired_q;
  assign stall_cycles_OUT  = stall_q;

endmodule
